// File: rtl/v68k_bus_responder.sv
// v68k_bus_responder
// Word-wide RAM/ROM target on the V68k asynchronous bus. A selected cycle is
// latched, held for a programmable number of wait states, then answered with
// DTACK (read data or completed write) or BERR (write into the read-only
// region). The answer is held until the master drops the address strobe.
module v68k_bus_responder #(
  parameter logic [23:1] BASE_ADDR   = 23'h080000,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ROM_WORDS   = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [23:1] i_a,
  input  logic        i_uds,
  input  logic        i_lds,
  input  logic        i_as,
  input  logic        i_rw,
  inout  tri   [15:0] io_d,
  output logic        o_dtack,
  output logic        o_berr
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cntNext;
  logic [ADDR_BITS-1:0]   r_idx;
  logic                   r_rw;
  logic                   r_uds;
  logic                   r_lds;
  logic                   r_rom;
  logic                   r_dtack;
  logic                   r_berr;
  logic                   w_dtackNext;
  logic                   w_berrNext;
  logic                   w_load;
  logic                   w_doRead;
  logic                   w_doWrite;
  logic [15:0]            r_dout;
  logic [15:0]            r_mem [DEPTH];

  logic                   w_sel;
  logic [ADDR_BITS-1:0]   w_idx;
  logic                   w_rom;
  logic                   w_oe;

  assign w_sel = i_as && (i_a[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
  assign w_idx = i_a[ADDR_BITS:1];

  // The read-only region is the bottom of the window; with no ROM words the
  // comparison would be constant, so it is dropped altogether.
  if (ROM_WORDS > 0) begin : g_rom
    localparam logic [ADDR_BITS:0] ROM_LIM = (ADDR_BITS+1)'(ROM_WORDS);
    assign w_rom = ({1'b0, w_idx} < ROM_LIM);
  end else begin : g_norom
    assign w_rom = 1'b0;
  end

  // Read data is only placed on the bus while a successful read is being
  // answered; releasing happens on the same edge that returns to idle.
  assign w_oe    = (r_state == S_RESPOND) && r_rw && !r_berr;
  assign io_d    = w_oe ? r_dout : {16{1'bz}};
  assign o_dtack = r_dtack;
  assign o_berr  = r_berr;

  // Next-state logic: latch on selection, count wait states, then answer.
  // Dropping AS during the wait aborts without touching memory.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_dtackNext = r_dtack;
    w_berrNext  = r_berr;
    w_load      = 1'b0;
    w_doRead    = 1'b0;
    w_doWrite   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel) begin
          w_load      = 1'b1;
          w_cntNext   = WS;
          w_stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_as) begin
          w_stateNext = S_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cntNext = r_cnt - 4'd1;
        end else begin
          w_stateNext = S_RESPOND;
          if (r_rw) begin
            w_doRead    = 1'b1;
            w_dtackNext = 1'b1;
          end else if (r_rom) begin
            w_berrNext  = 1'b1;
          end else begin
            w_doWrite   = 1'b1;
            w_dtackNext = 1'b1;
          end
        end
      end
      S_RESPOND: begin
        if (!i_as) begin
          w_stateNext = S_IDLE;
          w_dtackNext = 1'b0;
          w_berrNext  = 1'b0;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_dtackNext = 1'b0;
        w_berrNext  = 1'b0;
      end
    endcase
  end

  // State register and registered handshake outputs; reset kills any cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_dtack <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_dtack <= w_dtackNext;
      r_berr  <= w_berrNext;
    end
  end

  // Capture the cycle attributes once so later bus changes are ignored.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx <= '0;
      r_rw  <= 1'b0;
      r_uds <= 1'b0;
      r_lds <= 1'b0;
      r_rom <= 1'b0;
    end else if (w_load) begin
      r_idx <= w_idx;
      r_rw  <= i_rw;
      r_uds <= i_uds;
      r_lds <= i_lds;
      r_rom <= w_rom;
    end
  end

  // Storage array: byte-lane writes and full-word reads at the answering edge.
  // Contents survive reset; a reset edge never commits a pending write.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (w_doWrite && r_uds) begin
        r_mem[r_idx][15:8] <= io_d[15:8];
      end
      if (w_doWrite && r_lds) begin
        r_mem[r_idx][7:0] <= io_d[7:0];
      end
      if (w_doRead) begin
        r_dout <= r_mem[r_idx];
      end
    end
  end

endmodule

// File: tb/tb_v68k_bus_responder.sv
// tb_v68k_bus_responder
// Three responders share one bus at different windows: a ROM-fronted target
// with one wait state, a three-wait-state target and a zero-wait target.
// A behavioural model predicts every handshake and bus value each cycle.
module tb_v68k_bus_responder;

  localparam logic [23:1] BASES [3] = '{23'h080000, 23'h080400, 23'h080800};
  localparam int          WSS   [3] = '{1, 3, 0};
  localparam int          ROMS  [3] = '{4, 0, 0};
  localparam logic [15:0] SEQ   [8] = '{16'h1000, 16'h1111, 16'h1222, 16'h1333,
                                        16'h1444, 16'h1555, 16'h1666, 16'h1777};

  logic        clk = 1'b0;
  logic        reset;
  logic [23:1] a;
  logic        uds;
  logic        lds;
  logic        as;
  logic        rw;
  logic        tbDrive;
  logic [15:0] tbData;
  tri   [15:0] dBus;
  logic [2:0]  dtack;
  logic [2:0]  berr;

  int passCnt  = 0;
  int checkCnt = 0;
  int edgeCnt  = 0;

  assign dBus = tbDrive ? tbData : {16{1'bz}};

  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) edgeCnt++;

  v68k_bus_responder #(.BASE_ADDR(23'h080000), .ADDR_BITS(10), .WAIT_STATES(1), .ROM_WORDS(4)) u0 (
    .i_clk(clk), .i_reset(reset), .i_a(a), .i_uds(uds), .i_lds(lds), .i_as(as), .i_rw(rw),
    .io_d(dBus), .o_dtack(dtack[0]), .o_berr(berr[0]));
  v68k_bus_responder #(.BASE_ADDR(23'h080400), .ADDR_BITS(10), .WAIT_STATES(3), .ROM_WORDS(0)) u1 (
    .i_clk(clk), .i_reset(reset), .i_a(a), .i_uds(uds), .i_lds(lds), .i_as(as), .i_rw(rw),
    .io_d(dBus), .o_dtack(dtack[1]), .o_berr(berr[1]));
  v68k_bus_responder #(.BASE_ADDR(23'h080800), .ADDR_BITS(10), .WAIT_STATES(0), .ROM_WORDS(0)) u2 (
    .i_clk(clk), .i_reset(reset), .i_a(a), .i_uds(uds), .i_lds(lds), .i_as(as), .i_rw(rw),
    .io_d(dBus), .o_dtack(dtack[2]), .o_berr(berr[2]));

  // Model state per target: a cycle is open from selection until AS drops;
  // the answer comes once the wait budget has been used up.
  logic [15:0] mMem    [3][1024];
  bit          mKnownH [3][1024];
  bit          mKnownL [3][1024];
  bit          mBusy   [3];
  bit          mResp   [3];
  int          mElapsed[3];
  int          mIdx    [3];
  bit          mRw     [3];
  bit          mUds    [3];
  bit          mLds    [3];
  bit          mRom    [3];
  bit          mDtack  [3];
  bit          mBerr   [3];
  bit          mDrive  [3];
  bit          mDataOk [3];
  logic [15:0] mData   [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Behavioural model, advanced on each clock edge from the bus as driven.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        mBusy[k] = 0; mResp[k] = 0; mDtack[k] = 0; mBerr[k] = 0; mDrive[k] = 0;
      end else if (!mBusy[k]) begin
        if (as && (a[23:11] == BASES[k][23:11])) begin
          mBusy[k] = 1; mElapsed[k] = 0; mIdx[k] = int'(a[10:1]);
          mRw[k] = rw; mUds[k] = uds; mLds[k] = lds; mRom[k] = (int'(a[10:1]) < ROMS[k]);
        end
      end else if (!mResp[k]) begin
        if (!as) begin
          mBusy[k] = 0;
        end else if (mElapsed[k] == WSS[k]) begin
          mResp[k] = 1;
          if (mRw[k]) begin
            mDtack[k] = 1; mDrive[k] = 1; mData[k] = mMem[k][mIdx[k]];
            mDataOk[k] = mKnownH[k][mIdx[k]] && mKnownL[k][mIdx[k]];
          end else if (mRom[k]) begin
            mBerr[k] = 1;
          end else begin
            mDtack[k] = 1;
            if (mUds[k]) begin mMem[k][mIdx[k]][15:8] = dBus[15:8]; mKnownH[k][mIdx[k]] = 1; end
            if (mLds[k]) begin mMem[k][mIdx[k]][7:0] = dBus[7:0]; mKnownL[k][mIdx[k]] = 1; end
          end
        end else begin
          mElapsed[k]++;
        end
      end else if (!as) begin
        mBusy[k] = 0; mResp[k] = 0; mDtack[k] = 0; mBerr[k] = 0; mDrive[k] = 0;
      end
    end
  end

  // Every-cycle comparison of handshakes and bus against the model.
  always @(negedge clk) begin
    bit anyDrive;
    anyDrive = 0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dtack%0d", k), {31'd0, dtack[k]}, {31'd0, mDtack[k]});
      check($sformatf("berr%0d", k), {31'd0, berr[k]}, {31'd0, mBerr[k]});
      if (mDrive[k]) begin
        anyDrive = 1;
        if (mDataOk[k]) check($sformatf("rdata%0d", k), {16'd0, dBus}, {16'd0, mData[k]});
      end
    end
    if (!anyDrive && !tbDrive)
      check("bus_released", {31'd0, (dBus === 16'hzzzz) || (dBus === 16'h0000)}, 32'd1);
  end

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  // One complete master cycle: strobe, wait for an answer, release, idle edge.
  task automatic applyStimulus(input logic [23:1] addr, input logic isRead,
                               input logic u, input logic l, input logic [15:0] wdata,
                               output logic [15:0] rdata, output logic gotAck,
                               output logic gotBerr, output int lat);
    int start;
    bit seen;
    a = addr; rw = isRead; uds = u; lds = l; as = 1'b1;
    tbDrive = !isRead; tbData = wdata;
    start = edgeCnt; seen = 0; rdata = 16'h0; gotAck = 0; gotBerr = 0; lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      waitNeg();
      if (|dtack || |berr) begin
        seen = 1; rdata = dBus; gotAck = |dtack; gotBerr = |berr; lat = edgeCnt - start;
      end
    end
    check("cycle_answered", {31'd0, seen}, 32'd1);
    as = 1'b0; tbDrive = 1'b0;
    waitNeg();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] rdata, input logic gotAck,
                             input logic gotBerr, input logic [15:0] expData, input logic expAck,
                             input logic expBerr);
    check({name, "_ack"}, {31'd0, gotAck}, {31'd0, expAck});
    check({name, "_berr"}, {31'd0, gotBerr}, {31'd0, expBerr});
    if (expAck && rw) check({name, "_data"}, {16'd0, rdata}, {16'd0, expData});
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] romBefore;
    logic        ack;
    logic        be;
    int          lat;
    bit          stray;

    reset = 1'b1; as = 1'b1; a = 23'h080010; rw = 1'b1; uds = 1'b1; lds = 1'b1;
    tbDrive = 1'b0; tbData = 16'h0;
    waitNeg();
    waitNeg();
    check("reset_dtack", {29'd0, dtack}, 32'd0);
    check("reset_berr", {29'd0, berr}, 32'd0);
    reset = 1'b0; as = 1'b0;
    waitNeg();

    // Word write then read, with latency pinned.
    applyStimulus(23'h080010, 1'b0, 1'b1, 1'b1, 16'hBEEF, rd, ack, be, lat);
    checkOutput("wr_word", rd, ack, be, 16'h0, 1'b1, 1'b0);
    applyStimulus(23'h080010, 1'b1, 1'b1, 1'b1, 16'h0, rd, ack, be, lat);
    checkOutput("rd_word", rd, ack, be, 16'hBEEF, 1'b1, 1'b0);
    check("lat_ws1", lat, 32'd3);

    // Byte lanes.
    applyStimulus(23'h080020, 1'b0, 1'b1, 1'b1, 16'h1234, rd, ack, be, lat);
    applyStimulus(23'h080020, 1'b0, 1'b1, 1'b0, 16'hAB00, rd, ack, be, lat);
    applyStimulus(23'h080020, 1'b0, 1'b0, 1'b1, 16'h00CD, rd, ack, be, lat);
    applyStimulus(23'h080020, 1'b1, 1'b1, 1'b1, 16'h0, rd, ack, be, lat);
    checkOutput("rd_lanes", rd, ack, be, 16'hABCD, 1'b1, 1'b0);

    // Write with no strobes still acknowledges and changes nothing.
    applyStimulus(23'h080010, 1'b0, 1'b0, 1'b0, 16'hFFFF, rd, ack, be, lat);
    checkOutput("wr_nolane", rd, ack, be, 16'h0, 1'b1, 1'b0);
    applyStimulus(23'h080010, 1'b1, 1'b1, 1'b1, 16'h0, rd, ack, be, lat);
    checkOutput("rd_nolane", rd, ack, be, 16'hBEEF, 1'b1, 1'b0);

    // Read-only region rejects writes; first writable word accepts them.
    applyStimulus(23'h080002, 1'b1, 1'b1, 1'b1, 16'h0, romBefore, ack, be, lat);
    applyStimulus(23'h080002, 1'b0, 1'b1, 1'b1, 16'h5555, rd, ack, be, lat);
    checkOutput("wr_rom", rd, ack, be, 16'h0, 1'b0, 1'b1);
    applyStimulus(23'h080002, 1'b1, 1'b1, 1'b1, 16'h0, rd, ack, be, lat);
    checkOutput("rd_rom", rd, ack, be, romBefore, 1'b1, 1'b0);
    applyStimulus(23'h080004, 1'b0, 1'b1, 1'b1, 16'h7777, rd, ack, be, lat);
    checkOutput("wr_rom_edge", rd, ack, be, 16'h0, 1'b1, 1'b0);
    applyStimulus(23'h080004, 1'b1, 1'b1, 1'b1, 16'h0, rd, ack, be, lat);
    checkOutput("rd_rom_edge", rd, ack, be, 16'h7777, 1'b1, 1'b0);

    // Out-of-window read is ignored by every target.
    a = 23'h000010; rw = 1'b1; uds = 1'b1; lds = 1'b1; as = 1'b1; stray = 0;
    for (int i = 0; i < 10; i++) begin
      waitNeg();
      if (|dtack || |berr) stray = 1;
    end
    check("out_of_window", {31'd0, stray}, 32'd0);
    as = 1'b0;
    waitNeg();

    // Abort during wait states leaves memory alone.
    applyStimulus(23'h080405, 1'b0, 1'b1, 1'b1, 16'h2222, rd, ack, be, lat);
    a = 23'h080405; rw = 1'b0; uds = 1'b1; lds = 1'b1; as = 1'b1;
    tbDrive = 1'b1; tbData = 16'h1111;
    waitNeg();
    waitNeg();
    as = 1'b0; tbDrive = 1'b0; stray = 0;
    for (int i = 0; i < 6; i++) begin
      waitNeg();
      if (|dtack || |berr) stray = 1;
    end
    check("abort_quiet", {31'd0, stray}, 32'd0);
    applyStimulus(23'h080405, 1'b1, 1'b1, 1'b1, 16'h0, rd, ack, be, lat);
    checkOutput("rd_abort", rd, ack, be, 16'h2222, 1'b1, 1'b0);
    check("lat_ws3", lat, 32'd5);

    // Zero-wait target: sequential writes and back-to-back reads.
    for (int i = 0; i < 8; i++)
      applyStimulus(23'h080800 + 23'(i), 1'b0, 1'b1, 1'b1, SEQ[i], rd, ack, be, lat);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(23'h080800 + 23'(i), 1'b1, 1'b1, 1'b1, 16'h0, rd, ack, be, lat);
      checkOutput($sformatf("rd_seq%0d", i), rd, ack, be, SEQ[i], 1'b1, 1'b0);
      check($sformatf("lat_ws0_%0d", i), lat, 32'd2);
    end

    // Reset while answering drops DTACK on the next edge.
    a = 23'h080803; rw = 1'b1; uds = 1'b1; lds = 1'b1; as = 1'b1; stray = 0;
    for (int i = 0; i < 10 && !stray; i++) begin
      waitNeg();
      if (dtack[2]) stray = 1;
    end
    check("respond_reached", {31'd0, stray}, 32'd1);
    reset = 1'b1;
    waitNeg();
    check("reset_in_respond", {31'd0, dtack[2]}, 32'd0);
    reset = 1'b0; as = 1'b0;
    waitNeg();
    waitNeg();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
